pico_prog_loader: RTL and testbench
===================================

// Module: pico_prog_loader
// PURPOSE
//  Byte-stream program loader for the PicoMIPS core program memory.
//  - Receives a length-prefixed stream of 8-bit bytes and packs them into 24-bit instruction words.
//  - Writes the words to program memory from address 0 upward.
//  - Holds the core in HALTCOUNT (core_hold=1) for the whole load.
//  - Inverse of the assembler output path: the assembler emits 24-bit words, this block re-forms them for the fetch side.
// PARAMETERS
//  A  10  program memory address width (pico::A); capacity 2**A words
//  W  24  instruction width (`W_INST); must be 3*B
//  B  8   stream byte width (pico::N)
// PORTS
//  clk         in   1    single clock, all state on rising edge
//  rst         in   1    reset, asynchronous, active-high
//  start       in   1    1-cycle pulse: begin a new load
//  byte_in     in   B    stream byte
//  byte_valid  in   1    byte_in valid
//  byte_ready  out  1    loader accepts byte this cycle
//  mem_we      out  1    program memory write strobe (1 cycle per word)
//  mem_addr    out  A    program memory write address
//  mem_wdata   out  W    instruction word written
//  core_hold   out  1    1 = core PC forced to HALTCOUNT
//  done        out  1    load completed OK; held until next start/reset
//  err         out  1    length header > 2**A; held until next start/reset
//  word_count  out  A+1  words written in current load
// BEHAVIOUR
//  Reset: IDLE; byte_ready, mem_we, core_hold, done, err = 0; mem_addr, mem_wdata, word_count = 0.
//  Handshake: byte accepted iff byte_valid && byte_ready in same cycle; byte_ready is a function of state only.
//  Stream format:
//   - 16-bit big-endian length L (word count).
//   - L words, 3 bytes each, MSB first: word = {b0,b1,b2}, so b0[7:2] = opcode.
//  FSM:
//   - IDLE: byte_ready=0. start -> LEN_HI; clear done, err, word_count, mem_addr; core_hold=1.
//   - LEN_HI: byte_ready=1. On accept, latch L[15:8] -> LEN_LO.
//   - LEN_LO: byte_ready=1. On accept, latch L[7:0]. Next state from new L:
//       L==0 -> DONE; L>2**A -> ERR; else DATA with byte index 0.
//   - DATA: byte_ready=1. Accept bytes into shift register, index 0..2. On the 3rd accept -> WRITE.
//   - WRITE: byte_ready=0. mem_we=1 for exactly 1 cycle with current mem_addr and mem_wdata.
//       Next cycle: mem_addr+1, word_count+1; word_count==L -> DONE, else DATA.
//   - DONE: done=1, core_hold=0, byte_ready=0. Extra stream bytes are not accepted.
//   - ERR: err=1, core_hold=1, byte_ready=0, no further writes.
//  start: honoured in IDLE, DONE and ERR (restart clears all status); ignored in LEN_HI/LEN_LO/DATA/WRITE.
//  Latency: the write strobe is the cycle after the 3rd byte of a word is accepted.
//   - Peak rate is 3 bytes per 4 cycles.
//  Boundaries:
//   - L==2**A writes addresses 0..2**A-1; mem_addr never wraps and the last write goes to 2**A-1.
//   - word_count reaches 2**A, which is why it is A+1 bits wide.
//   - byte_valid low mid-word stalls with no timeout; partial bytes are retained.
//   - rst asserted mid-load aborts immediately to IDLE with reset values; written words are not undone.
//   - mem_we is never asserted outside WRITE; mem_wdata is stable while mem_we=1.
// TESTING
//  1. start; stream 00 02 | 44 20 03 | 44 40 02, byte_valid always high
//     -> writes 0x442003@0, 0x444002@1 (2 strobes), word_count=2, done=1, core_hold=0, err=0.
//  2. start; stream 00 00 -> DONE the cycle after the 2nd byte, no mem_we, done=1, core_hold=0.
//  3. start; stream 04 01 (L=1025) -> err=1, core_hold=1, byte_ready=0, no mem_we;
//     then start -> err=0, state LEN_HI.
//  4. L=1024 with random words
//     -> 1024 strobes, addresses 0..1023 in order, word_count=1024, no wrap, done=1.
//  5. Random byte_valid gaps (50%) on test 1 stream
//     -> identical writes; byte_ready=0 during every WRITE cycle.
//  6. rst pulse after 4 data bytes of an L=3 load
//     -> all outputs at reset values asynchronously;
//     a fresh start with a full stream then loads correctly from address 0.

Source files
------------

// File: rtl/pico_prog_loader.sv
// Byte-stream program loader for the PicoMIPS program memory.
// Packs a length-prefixed byte stream into instruction words.
module pico_prog_loader #(
  parameter int A = 10,
  parameter int W = 24,
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [B-1:0] byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         core_hold,
  output logic         done,
  output logic         err,
  output logic [A:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR
  } state_t;

  localparam int unsigned CAP = 2 ** A;

  state_t         state;
  logic [2*B-1:0] len;
  logic [2*B-1:0] len_new;
  logic [1:0]     idx;
  logic           accept;
  logic           last;

  assign accept  = byte_valid && byte_ready;
  assign len_new = {len[2*B-1:B], byte_in};
  assign last    = (32'(word_count) + 32'd1) == 32'(len);

  // Status outputs decode the state register directly.
  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    core_hold  = 1'b1;
    unique case (state)
      IDLE:   core_hold = 1'b0;
      LEN_HI: byte_ready = 1'b1;
      LEN_LO: byte_ready = 1'b1;
      DATA:   byte_ready = 1'b1;
      WRITE:  mem_we = 1'b1;
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
      end
      ERR:    err = 1'b1;
      default: core_hold = 1'b0;
    endcase
  end

  // Load sequencer: header, byte packing, one write per word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      idx        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN_HI;
            word_count <= '0;
            mem_addr   <= '0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[2*B-1:B] <= byte_in;
            state        <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[B-1:0] <= byte_in;
            idx        <= '0;
            if (len_new == '0)
              state <= DONE;
            else if (32'(len_new) > CAP)
              state <= ERR;
            else
              state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            mem_wdata <= {mem_wdata[W-B-1:0], byte_in};
            if (idx == 2'd2) begin
              idx   <= '0;
              state <= WRITE;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        WRITE: begin
          word_count <= word_count + (A+1)'(1);
          if (last) begin
            state <= DONE;
          end else begin
            state    <= DATA;
            mem_addr <= mem_addr + A'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_prog_loader.sv
// Directed bench for pico_prog_loader.
// Each task drives one scenario and checks it inline.
module tb_pico_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [23:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;
  logic [10:0] word_count;

  int compared = 0;
  int mismatched = 0;

  logic [9:0]  aq[$];
  logic [23:0] dq[$];
  int          rdy_bad = 0;
  logic [23:0] words[1024];

  pico_prog_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Log every write strobe and whether byte_ready leaked high.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      aq.push_back(mem_addr);
      dq.push_back(mem_wdata);
      if (byte_ready !== 1'b0) rdy_bad++;
    end
  end

  task automatic clear_log();
    aq.delete();
    dq.delete();
    rdy_bad = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL send_byte timeout: byte_ready=%b required 1", byte_ready);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_basic(input int rnd);
    logic [7:0] s[8];
    s = '{8'h00, 8'h02, 8'h44, 8'h20, 8'h03, 8'h44, 8'h40, 8'h02};
    for (int i = 0; i < 8; i++)
      send_byte(s[i], rnd ? int'($urandom_range(0, 1)) : 0);
  endtask

  task automatic check_basic(input string tag);
    compared++;
    if (aq.size() !== 2) begin
      mismatched++;
      $display("FAIL %s strobes: got %0d required 2", tag, aq.size());
    end else begin
      compared++;
      if (aq[0] !== 10'd0 || dq[0] !== 24'h442003) begin
        mismatched++;
        $display("FAIL %s word0: got %h@%0d required 442003@0",
                 tag, dq[0], aq[0]);
      end
      compared++;
      if (aq[1] !== 10'd1 || dq[1] !== 24'h444002) begin
        mismatched++;
        $display("FAIL %s word1: got %h@%0d required 444002@1",
                 tag, dq[1], aq[1]);
      end
    end
    compared++;
    if (word_count !== 11'd2 || done !== 1'b1 ||
        core_hold !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL %s status: wc=%0d done=%b hold=%b err=%b required 2 1 0 0",
               tag, word_count, done, core_hold, err);
    end
    compared++;
    if (rdy_bad !== 0) begin
      mismatched++;
      $display("FAIL %s ready_in_write: got %0d required 0", tag, rdy_bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({byte_ready, mem_we, core_hold, done, err} !== 5'b0 ||
        mem_addr !== 10'd0 || mem_wdata !== 24'd0 || word_count !== 11'd0) begin
      mismatched++;
      $display("FAIL reset: rdy=%b we=%b hold=%b done=%b err=%b addr=%0d wd=%h wc=%0d required all 0",
               byte_ready, mem_we, core_hold, done, err, mem_addr, mem_wdata, word_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_log();
    do_start();
    compared++;
    if (byte_ready !== 1'b1 || core_hold !== 1'b1) begin
      mismatched++;
      $display("FAIL start_len_hi: rdy=%b hold=%b required 1 1",
               byte_ready, core_hold);
    end
    send_basic(0);
    repeat (3) @(negedge clk);
    check_basic("basic");
    compared++;
    if (byte_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL done_ready: got %b required 0", byte_ready);
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    compared++;
    if (done !== 1'b1 || core_hold !== 1'b0 || word_count !== 11'd0) begin
      mismatched++;
      $display("FAIL zero_len: done=%b hold=%b wc=%0d required 1 0 0",
               done, core_hold, word_count);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (aq.size() !== 0) begin
      mismatched++;
      $display("FAIL zero_len strobes: got %0d required 0", aq.size());
    end
  endtask

  task automatic test_err();
    clear_log();
    do_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    repeat (3) @(negedge clk);
    compared++;
    if (err !== 1'b1 || core_hold !== 1'b1 || byte_ready !== 1'b0 ||
        done !== 1'b0 || aq.size() !== 0) begin
      mismatched++;
      $display("FAIL err_len: err=%b hold=%b rdy=%b done=%b we=%0d required 1 1 0 0 0",
               err, core_hold, byte_ready, done, aq.size());
    end
    do_start();
    compared++;
    if (err !== 1'b0 || byte_ready !== 1'b1 || core_hold !== 1'b1) begin
      mismatched++;
      $display("FAIL err_restart: err=%b rdy=%b hold=%b required 0 1 1",
               err, byte_ready, core_hold);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
  endtask

  task automatic test_full();
    int bad;
    clear_log();
    for (int i = 0; i < 1024; i++) words[i] = 24'($urandom);
    do_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 1024; i++) begin
      send_byte(words[i][23:16], 0);
      send_byte(words[i][15:8], 0);
      send_byte(words[i][7:0], 0);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (aq.size() !== 1024) begin
      mismatched++;
      $display("FAIL full strobes: got %0d required 1024", aq.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 1024 && bad == 0; i++) begin
        compared++;
        if (aq[i] !== 10'(i) || dq[i] !== words[i]) begin
          mismatched++;
          bad = 1;
          $display("FAIL full word%0d: got %h@%0d required %h@%0d",
                   i, dq[i], aq[i], words[i], i);
        end
      end
    end
    compared++;
    if (word_count !== 11'd1024 || mem_addr !== 10'd1023 ||
        done !== 1'b1 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL full status: wc=%0d addr=%0d done=%b err=%b required 1024 1023 1 0",
               word_count, mem_addr, done, err);
    end
  endtask

  task automatic test_gaps();
    clear_log();
    do_start();
    send_basic(1);
    repeat (3) @(negedge clk);
    check_basic("gaps");
  endtask

  task automatic test_abort();
    clear_log();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h55, 0);
    rst = 1'b1;
    #1;
    compared++;
    if ({byte_ready, mem_we, core_hold, done, err} !== 5'b0 ||
        mem_addr !== 10'd0 || mem_wdata !== 24'd0 || word_count !== 11'd0) begin
      mismatched++;
      $display("FAIL abort: rdy=%b we=%b hold=%b done=%b err=%b addr=%0d wd=%h wc=%0d required all 0",
               byte_ready, mem_we, core_hold, done, err, mem_addr, mem_wdata, word_count);
    end
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if (aq.size() !== 1 || dq[0] !== 24'h112233) begin
      mismatched++;
      $display("FAIL abort prior write: n=%0d required 1 word 112233", aq.size());
    end
    clear_log();
    do_start();
    send_basic(0);
    repeat (3) @(negedge clk);
    check_basic("reload");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_err();
    test_full();
    test_gaps();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
